// File: rtl/hazard_if.sv
// Hazard-unit port bundle: pipeline register fields in, forwarding/stall controls out.
// master = pipeline side, slave = hazard_unit.
interface hazard_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       WriteRegE;
    logic [4:0]       WriteRegM;
    logic [4:0]       WriteRegW;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             MemtoRegM;
    logic             BranchD;
    logic             MdStartE;
    logic             MdUseD;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             ForwardAD;
    logic             ForwardBD;
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic             MdBusy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MdStartE, MdUseD,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, MdBusy, StallCount
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MdStartE, MdUseD,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, MdBusy, StallCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: E/D forwarding, load-use / branch / mult-div stalls,
// mult-div busy tracker and a saturating stalled-cycle counter.
module hazard_unit #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    hazard_if.slave hz
);

    localparam int unsigned MD_CNT_W = 8;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e         md_state;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    logic md_busy;
    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;
    logic e_hits_d;
    logic m_load_hits_d;

    // Execute-stage operand select: M result wins over W result, r0 never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wr_m,
        input logic [4:0] dst_m,
        input logic       wr_w,
        input logic [4:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (dst_m != 5'd0) && (dst_m == src)) begin
            sel = 2'b10;
        end else if (wr_w && (dst_w != 5'd0) && (dst_w == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign md_busy = (md_state == MD_BUSY);

    always_comb begin
        hz.ForwardAE = fwd_sel(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        hz.ForwardBE = fwd_sel(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        hz.ForwardAD = hz.RegWriteM && (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RsD);
        hz.ForwardBD = hz.RegWriteM && (hz.WriteRegM != 5'd0) && (hz.WriteRegM == hz.RtD);
    end

    // Hazard detection; any cause freezes F/D and bubbles E together.
    always_comb begin
        lwstall = hz.MemtoRegE && (hz.WriteRegE != 5'd0) &&
                  ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));
        e_hits_d = hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                   ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));
        m_load_hits_d = hz.MemtoRegM && (hz.WriteRegM != 5'd0) &&
                        ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD));
        brstall = hz.BranchD && (e_hits_d || m_load_hits_d);
        mdstall = hz.MdUseD && (md_busy || hz.MdStartE);
        stall   = lwstall || brstall || mdstall;
        hz.StallF = stall;
        hz.StallD = stall;
        hz.FlushE = stall;
        hz.MdBusy = md_busy;
        hz.StallCount = stall_cnt;
    end

    // Busy window is cycles k+1..k+MD_LATENCY-1 after issue at edge k, so the
    // exit is taken on the edge where the countdown reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (hz.MdStartE) begin
                        md_cnt   <= MD_CNT_W'(MD_LATENCY - 1);
                        md_state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - MD_CNT_W'(1);
                    if (md_cnt == MD_CNT_W'(1)) begin
                        md_state <= MD_IDLE;
                    end
                end
                default: begin
                    md_state <= MD_IDLE;
                    md_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; expectations queued by the driver,
// compared by a negedge monitor.
module tb_hazard_unit;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 4;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       fad;
        logic       fbd;
        logic       st;
        logic       bz;
        logic [3:0] sc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [3:0] sc_model;

    exp_t  q[$];
    string nq[$];
    exp_t  cur;
    string cur_nm;

    hazard_if #(.CNT_W(CW)) hz();

    hazard_unit #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input string f, input logic [3:0] act, input logic [3:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, expv);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle with a queued vector is checked.
    always @(negedge clk) begin
        if (hz.MdStartE) begin
            chk("md_start_while_busy", "MdBusy", {3'b0, hz.MdBusy}, 4'd0);
        end
        if (q.size() > 0) begin
            cur    = q.pop_front();
            cur_nm = nq.pop_front();
            chk(cur_nm, "ForwardAE",  {2'b0, hz.ForwardAE}, {2'b0, cur.fa});
            chk(cur_nm, "ForwardBE",  {2'b0, hz.ForwardBE}, {2'b0, cur.fb});
            chk(cur_nm, "ForwardAD",  {3'b0, hz.ForwardAD}, {3'b0, cur.fad});
            chk(cur_nm, "ForwardBD",  {3'b0, hz.ForwardBD}, {3'b0, cur.fbd});
            chk(cur_nm, "StallF",     {3'b0, hz.StallF},    {3'b0, cur.st});
            chk(cur_nm, "StallD",     {3'b0, hz.StallD},    {3'b0, cur.st});
            chk(cur_nm, "FlushE",     {3'b0, hz.FlushE},    {3'b0, cur.st});
            chk(cur_nm, "MdBusy",     {3'b0, hz.MdBusy},    {3'b0, cur.bz});
            chk(cur_nm, "StallCount", hz.StallCount,        cur.sc);
        end
    end

    // Queue one expected response, then advance a cycle and update the counter model.
    task automatic vec(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic fad, input logic fbd, input logic st, input logic bz);
        exp_t e;
        e.fa  = fa;
        e.fb  = fb;
        e.fad = fad;
        e.fbd = fbd;
        e.st  = st;
        e.bz  = bz;
        e.sc  = sc_model;
        q.push_back(e);
        nq.push_back(nm);
        @(posedge clk);
        if (st && rst_n && (sc_model != 4'hF)) sc_model = sc_model + 4'd1;
        #1;
    endtask

    task automatic clear_inputs();
        hz.RsD = 5'd0; hz.RtD = 5'd0; hz.RsE = 5'd0; hz.RtE = 5'd0;
        hz.WriteRegE = 5'd0; hz.WriteRegM = 5'd0; hz.WriteRegW = 5'd0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0; hz.BranchD = 1'b0;
        hz.MdStartE = 1'b0; hz.MdUseD = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        sc_model = 4'd0;
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        vec("reset", 2'b00, 2'b00, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Execute forwarding and priority
        hz.RsE = 5'd5; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd5;
        hz.RegWriteW = 1'b1; hz.WriteRegW = 5'd5;
        vec("fwd_a_m", 2'b10, 2'b00, 0, 0, 0, 0);
        hz.RegWriteM = 1'b0;
        vec("fwd_a_w", 2'b01, 2'b00, 0, 0, 0, 0);
        hz.RsE = 5'd0; hz.WriteRegM = 5'd0; hz.RegWriteM = 1'b1; hz.RtE = 5'd5;
        vec("fwd_r0_b_w", 2'b00, 2'b01, 0, 0, 0, 0);
        hz.RsE = 5'd7; hz.RtE = 5'd7; hz.WriteRegM = 5'd7; hz.WriteRegW = 5'd7;
        vec("fwd_m_prio", 2'b10, 2'b10, 0, 0, 0, 0);

        // Load-use
        clear_inputs();
        hz.MemtoRegE = 1'b1; hz.WriteRegE = 5'd8; hz.RtD = 5'd8;
        vec("lwstall", 2'b00, 2'b00, 0, 0, 1, 0);
        hz.WriteRegE = 5'd0;
        vec("lw_r0", 2'b00, 2'b00, 0, 0, 0, 0);

        // Branch compare hazards
        clear_inputs();
        hz.BranchD = 1'b1; hz.RsD = 5'd3; hz.MemtoRegM = 1'b1; hz.WriteRegM = 5'd3;
        vec("br_load_m", 2'b00, 2'b00, 0, 0, 1, 0);
        hz.RegWriteM = 1'b1; hz.MemtoRegM = 1'b0;
        vec("br_fwd_ad", 2'b00, 2'b00, 1, 0, 0, 0);
        clear_inputs();
        hz.BranchD = 1'b1; hz.RsD = 5'd3; hz.RtD = 5'd4; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd4;
        vec("br_alu_e", 2'b00, 2'b00, 0, 0, 1, 0);
        hz.BranchD = 1'b0;
        vec("no_branch", 2'b00, 2'b00, 0, 0, 0, 0);
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd9; hz.RtD = 5'd9;
        vec("fwd_bd", 2'b00, 2'b00, 0, 1, 0, 0);

        // Mult/div dependent use: stall cycles 0..3, release at 4
        clear_inputs();
        hz.MdStartE = 1'b1; hz.MdUseD = 1'b1;
        vec("md_issue", 2'b00, 2'b00, 0, 0, 1, 0);
        hz.MdStartE = 1'b0;
        for (int i = 1; i < int'(LAT); i++) vec("md_busy", 2'b00, 2'b00, 0, 0, 1, 1);
        vec("md_release", 2'b00, 2'b00, 0, 0, 0, 0);

        // Start coincident with a load-use flush is still taken
        clear_inputs();
        hz.MemtoRegE = 1'b1; hz.WriteRegE = 5'd8; hz.RsD = 5'd8; hz.MdStartE = 1'b1;
        vec("md_start_flush", 2'b00, 2'b00, 0, 0, 1, 0);
        clear_inputs();
        vec("md_busy_nouse", 2'b00, 2'b00, 0, 0, 0, 1);

        // Async reset in the second BUSY cycle
        rst_n = 1'b0;
        sc_model = 4'd0;
        hz.MdUseD = 1'b1;
        vec("rst_mid_busy", 2'b00, 2'b00, 0, 0, 0, 0);
        rst_n = 1'b1;
        vec("post_rst_idle", 2'b00, 2'b00, 0, 0, 0, 0);

        // Counter saturation
        clear_inputs();
        hz.MemtoRegE = 1'b1; hz.WriteRegE = 5'd8; hz.RsD = 5'd8;
        for (int i = 0; i < 20; i++) vec("sat_stall", 2'b00, 2'b00, 0, 0, 1, 0);
        clear_inputs();
        vec("sat_hold", 2'b00, 2'b00, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("drain", "pending", 4'(q.size()), 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It generates the execute-stage forwarding selects and decode-stage branch-compare forwards. It detects load-use and branch-operand hazards and stalls/bubbles the front end. It also tracks a multi-cycle multiply/divide unit with an internal busy state machine. It sits beside the pipeline registers and drives ForwardAE/ForwardBE into the execute stage, StallF/StallD into the fetch/decode registers, and FlushE into the ID/EX register.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue (legal range 2..255)
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- RsD, RtD  in  5  source registers of instruction in Decode
- RsE, RtE  in  5  source registers of instruction in Execute
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables in E/M/W
- MemtoRegE, MemtoRegM  in  1  instruction in E/M is a load
- BranchD  in  1  Decode holds a branch (compare done in D)
- MdStartE  in  1  mult/div issued from Execute this cycle
- MdUseD  in  1  Decode instruction reads HI/LO or is a mult/div
- ForwardAE, ForwardBE  out  2  srcA/srcB select: 00 register file, 01 ResultW, 10 ALUOutM
- ForwardAD, ForwardBD  out  1  forward ALUOutM to Decode compare operands
- StallF, StallD  out  1  hold PC / IF-ID register
- FlushE  out  1  clear ID/EX register (insert bubble)
- MdBusy  out  1  mult/div unit busy
- StallCount  out  CNT_W  total stalled cycles since reset, saturating

## Operation
- ForwardAE: 10 if RegWriteM && WriteRegM!=0 && WriteRegM==RsE; else 01 if RegWriteW && WriteRegW!=0 && WriteRegW==RsE; else 00. Same for ForwardBE with RtE. M has priority over W. 11 is never driven.
- ForwardAD = RegWriteM && WriteRegM!=0 && WriteRegM==RsD. ForwardBD is the same check against RtD.
- lwstall = MemtoRegE && WriteRegE!=0 && (WriteRegE==RsD || WriteRegE==RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD})).
- mdstall = MdUseD && (MdBusy || MdStartE).
- StallF = StallD = FlushE = lwstall | brstall | mdstall. All of these are combinational from the inputs and the current state.
- Mult/div FSM:
  - IDLE: on MdStartE, load cnt = MD_LATENCY-1 and go to BUSY.
  - BUSY: decrement cnt each cycle. When cnt==0 at a clock edge, go to IDLE.
  - MdBusy = (state==BUSY).
  - MdStartE while BUSY is illegal, because mdstall prevents it. It is ignored (no reload), and the bench flags it.
- StallCount increments by 1 on each clock edge where StallD=1, and saturates at all-ones.

## Timing
- Reset (rst_n low, async): state=IDLE, cnt=0, MdBusy=0, StallCount=0, effective immediately. Combinational outputs then follow the inputs with mdstall depending only on MdStartE.
- Reset asserted mid-BUSY: MdBusy drops the same instant. It stays 0 until a new MdStartE after reset release.
- MdStartE sampled at edge k: MdBusy=1 for cycles k+1..k+MD_LATENCY-1 and 0 from k+MD_LATENCY. A dependent MdUseD is released in cycle k+MD_LATENCY.
- MdStartE and MdUseD in the same cycle: stall that cycle. BUSY starts next edge.
- MdStartE coincident with FlushE: start still taken, because the instruction in E is committed.
- Forwarding and stall outputs have zero-cycle latency (same-cycle combinational). Only the FSM and StallCount are registered.
- All hazards stall together. StallCount counts one per stalled cycle regardless of how many causes are active.

## Test plan
- RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 -> ForwardAE=10. Drop RegWriteM -> 01. Set RsE=0 with WriteRegM=0 -> 00.
- MemtoRegE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1 for one cycle, StallCount 0->1. Same with WriteRegE=0 -> no stall.
- BranchD=1, RsD=3, MemtoRegM=1, WriteRegM=3 -> stall. Next cycle RegWriteM=1, MemtoRegM=0 -> no stall and ForwardAD=1.
- MD_LATENCY=4: MdStartE pulse at edge 0, MdUseD held high -> MdBusy=1 for cycles 1-3, stall in cycles 0-3, released at cycle 4. StallCount=4.
- rst_n pulsed low in cycle 2 of BUSY -> MdBusy=0 and StallCount=0 immediately. With MdUseD=1 and MdStartE=0, no stall.
- CNT_W=4: hold lwstall condition 20 cycles -> StallCount saturates at 15.
